// File: rtl/i2c_master_writer.sv
`default_nettype none
// ============================================================================
// Module   : i2c_master_writer
// Brief    : Single-byte I2C bus master. START, 7-bit address + R/W, one data
//            byte (write or read), STOP, with slave ACK checking. Open-drain
//            style: the *_oe outputs pull a line low when 1, release when 0.
// Options  : I2C_CLOCK_STRETCH_EN adds scl_in and lets a slave stretch the
//            SCL high phases by holding the quarter timer.
// Revision : 1.0 - initial release
// ============================================================================
module i2c_master_writer #(
    parameter int CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [6:0] dev_addr,
    input  logic       rw,
    input  logic [7:0] wdata,
    input  logic       sda_in,
`ifdef I2C_CLOCK_STRETCH_EN
    input  logic       scl_in,
`endif
    output logic       scl_oe,
    output logic       sda_oe,
    output logic       busy,
    output logic       done,
    output logic       ack_err,
    output logic [7:0] rdata
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_ADDR  = 3'd2,
        ST_ACK1  = 3'd3,
        ST_DATA  = 3'd4,
        ST_ACK2  = 3'd5,
        ST_STOP  = 3'd6,
        ST_DONE  = 3'd7
    } state_t;

    // Last count of the quarter timer.
    localparam logic [7:0] QMAX = 8'(CLK_DIV - 1);

    state_t     state_q,   state_d;
    logic [7:0] qcnt_q,    qcnt_d;
    logic [1:0] qtr_q,     qtr_d;
    logic [2:0] bit_q,     bit_d;
    logic [7:0] shift_q,   shift_d;
    logic [7:0] wdata_q,   wdata_d;
    logic       rw_q,      rw_d;
    logic       samp_q,    samp_d;
    logic       ack_err_q, ack_err_d;
    logic [7:0] rdata_q,   rdata_d;
    logic       scl_oe_q,  scl_oe_d;
    logic       sda_oe_q,  sda_oe_d;
    logic       busy_q,    busy_d;
    logic       done_q,    done_d;

    logic w_active;
    logic w_in_slot;
    logic w_hold;
    logic w_qend;
    logic w_sample;
    logic w_slot_end;

    // SCL is pulled low in the first half of every data/ack slot and in the
    // first quarter of STOP; released everywhere else.
    function automatic logic scl_low_f(input state_t st, input logic [1:0] q);
        logic r;
        r = 1'b0;
        case (st)
            ST_ADDR, ST_ACK1, ST_DATA, ST_ACK2: r = (q < 2'd2);
            ST_STOP:                            r = (q == 2'd0);
            default:                            r = 1'b0;
        endcase
        return r;
    endfunction

    // SDA drive: START falls in its second half, STOP rises in its last
    // quarter, data slots drive the shift register MSB (write only).
    function automatic logic sda_low_f(input state_t st, input logic [1:0] q,
                                       input logic b7, input logic rd);
        logic r;
        r = 1'b0;
        case (st)
            ST_START: r = (q >= 2'd2);
            ST_ADDR:  r = ~b7;
            ST_DATA:  r = ~rd & ~b7;
            ST_STOP:  r = (q != 2'd3);
            default:  r = 1'b0;
        endcase
        return r;
    endfunction

    assign w_active  = (state_q != ST_IDLE) && (state_q != ST_DONE);
    assign w_in_slot = (state_q == ST_ADDR) || (state_q == ST_ACK1) ||
                       (state_q == ST_DATA) || (state_q == ST_ACK2);

`ifdef I2C_CLOCK_STRETCH_EN
    // A slave holding SCL low at the start of a high phase freezes the timer.
    assign w_hold = ~scl_in && (qcnt_q == 8'd0) &&
                    ((w_in_slot && (qtr_q == 2'd2)) ||
                     ((state_q == ST_STOP) && ((qtr_q == 2'd1) || (qtr_q == 2'd2))));
`else
    assign w_hold = 1'b0;
`endif

    assign w_qend     = w_active && ~w_hold && (qcnt_q == QMAX);
    assign w_sample   = w_qend && (qtr_q == 2'd2);
    assign w_slot_end = w_qend && (qtr_q == 2'd3);

    // Next-state, datapath and registered-output decode.
    always_comb begin
        state_d   = state_q;
        qcnt_d    = qcnt_q;
        qtr_d     = qtr_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
        wdata_d   = wdata_q;
        rw_d      = rw_q;
        samp_d    = samp_q;
        ack_err_d = ack_err_q;
        rdata_d   = rdata_q;

        if (w_active) begin
            if (w_qend) begin
                qcnt_d = 8'd0;
                qtr_d  = qtr_q + 2'd1;
            end else if (!w_hold) begin
                qcnt_d = qcnt_q + 8'd1;
            end
        end else begin
            qcnt_d = 8'd0;
            qtr_d  = 2'd0;
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d   = ST_START;
                    shift_d   = {dev_addr, rw};
                    wdata_d   = wdata;
                    rw_d      = rw;
                    ack_err_d = 1'b0;
                    bit_d     = 3'd0;
                end
            end
            ST_START: begin
                if (w_slot_end) begin
                    state_d = ST_ADDR;
                    bit_d   = 3'd0;
                end
            end
            ST_ADDR: begin
                if (w_slot_end) begin
                    shift_d = {shift_q[6:0], 1'b0};
                    if (bit_q == 3'd7) begin
                        state_d = ST_ACK1;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
            ST_ACK1: begin
                if (w_sample) begin
                    samp_d = sda_in;
                end
                if (w_slot_end) begin
                    if (samp_q) begin
                        ack_err_d = 1'b1;
                        state_d   = ST_STOP;
                    end else begin
                        state_d = ST_DATA;
                        bit_d   = 3'd0;
                        shift_d = rw_q ? 8'h00 : wdata_q;
                    end
                end
            end
            ST_DATA: begin
                if (w_sample && rw_q) begin
                    shift_d = {shift_q[6:0], sda_in};
                end
                if (w_slot_end) begin
                    if (!rw_q) begin
                        shift_d = {shift_q[6:0], 1'b0};
                    end
                    if (bit_q == 3'd7) begin
                        state_d = ST_ACK2;
                        if (rw_q) begin
                            rdata_d = shift_q;
                        end
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
            ST_ACK2: begin
                if (w_sample) begin
                    samp_d = sda_in;
                end
                if (w_slot_end) begin
                    // A read ends with our own NACK, so only writes are checked.
                    if (!rw_q && samp_q) begin
                        ack_err_d = 1'b1;
                    end
                    state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                if (w_slot_end) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        scl_oe_d = scl_low_f(state_d, qtr_d);
        sda_oe_d = sda_low_f(state_d, qtr_d, shift_d[7], rw_d);
        busy_d   = (state_d != ST_IDLE) && (state_d != ST_DONE);
        done_d   = (state_d == ST_DONE);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            qcnt_q    <= 8'd0;
            qtr_q     <= 2'd0;
            bit_q     <= 3'd0;
            shift_q   <= 8'h00;
            wdata_q   <= 8'h00;
            rw_q      <= 1'b0;
            samp_q    <= 1'b0;
            ack_err_q <= 1'b0;
            rdata_q   <= 8'h00;
            scl_oe_q  <= 1'b0;
            sda_oe_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            qcnt_q    <= qcnt_d;
            qtr_q     <= qtr_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            wdata_q   <= wdata_d;
            rw_q      <= rw_d;
            samp_q    <= samp_d;
            ack_err_q <= ack_err_d;
            rdata_q   <= rdata_d;
            scl_oe_q  <= scl_oe_d;
            sda_oe_q  <= sda_oe_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign scl_oe  = scl_oe_q;
    assign sda_oe  = sda_oe_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign ack_err = ack_err_q;
    assign rdata   = rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_i2c_master_writer.sv
`default_nettype none
// ============================================================================
// Module   : tb_i2c_master_writer
// Brief    : Directed self-checking bench for i2c_master_writer (CLK_DIV=4).
//            Cycle offsets t count rising edges after the edge that accepts
//            start; outputs are sampled on the falling edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_i2c_master_writer;

    localparam int CD   = 4;
    localparam int SLOT = 4 * CD;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [6:0] dev_addr;
    logic       rw;
    logic [7:0] wdata;
    logic       sda_in;
    logic       slave_sda;
    logic       scl_oe;
    logic       sda_oe;
    logic       busy;
    logic       done;
    logic       ack_err;
    logic [7:0] rdata;
`ifdef I2C_CLOCK_STRETCH_EN
    logic       scl_in;
`endif

    int n_cmp;
    int n_bad;

    // Wired-AND bus: master pulls low via sda_oe, slave via slave_sda=0.
    assign sda_in = ~sda_oe & slave_sda;

    i2c_master_writer #(.CLK_DIV(CD)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .dev_addr (dev_addr),
        .rw       (rw),
        .wdata    (wdata),
        .sda_in   (sda_in),
`ifdef I2C_CLOCK_STRETCH_EN
        .scl_in   (scl_in),
`endif
        .scl_oe   (scl_oe),
        .sda_oe   (sda_oe),
        .busy     (busy),
        .done     (done),
        .ack_err  (ack_err),
        .rdata    (rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Records the master's SDA level (1 = released) at every SCL rise.
    logic        mon_clr;
    logic        mon_prev;
    int          mon_cnt;
    logic [31:0] mon_bits;
    always @(posedge clk) begin
        if (mon_clr) begin
            mon_cnt  <= 0;
            mon_bits <= '0;
            mon_prev <= 1'b0;
        end else begin
            if (mon_prev && !scl_oe) begin
                mon_cnt  <= mon_cnt + 1;
                mon_bits <= {mon_bits[30:0], ~sda_oe};
            end
            mon_prev <= scl_oe;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Present a request and let the next rising edge accept it.
    task automatic accept(input logic [6:0] a, input logic r, input logic [7:0] wd);
        @(negedge clk);
        dev_addr  = a;
        rw        = r;
        wdata     = wd;
        start     = 1'b1;
        mon_clr   = 1'b1;
        slave_sda = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start   = 1'b0;
        mon_clr = 1'b0;
    endtask

    // Run one transaction for max_t cycles, acting as the slave by slot
    // position. ack1/ack2: 0 = slave ACKs. bp_t pulses start, rst_t resets.
    task automatic run_txn(input logic [6:0] a, input logic r, input logic [7:0] wd,
                           input logic ack1, input logic ack2, input logic [7:0] rb,
                           input int bp_t, input int rst_t, input int stretch, input int max_t,
                           output int first_done, output int n_done,
                           output logic err_at_done, output logic [7:0] rd_at_done,
                           output logic [3:0] rst_snap);
        int ts;
        int slot;
        first_done  = -1;
        n_done      = 0;
        err_at_done = 1'bx;
        rd_at_done  = 8'hxx;
        rst_snap    = 4'hx;
        accept(a, r, wd);
        for (int t = 1; t <= max_t; t++) begin
            @(posedge clk);
            @(negedge clk);
            if (done) begin
                n_done++;
                if (first_done < 0) begin
                    first_done  = t;
                    err_at_done = ack_err;
                    rd_at_done  = rdata;
                end
            end
            start = (t == bp_t);
            if (t == rst_t) rst_n = 1'b0;
            if (t == rst_t + 1) begin
                rst_snap = {scl_oe, sda_oe, busy, done};
                rst_n    = 1'b1;
            end
`ifdef I2C_CLOCK_STRETCH_EN
            scl_in = !(stretch != 0 && t >= 6 * CD && t < 6 * CD + 10);
`endif
            ts = (stretch != 0 && t >= 6 * CD + 10) ? t - 10 : t;
            slot = ts / SLOT;
            slave_sda = 1'b1;
            if (slot == 9)                          slave_sda = ack1;
            else if (slot == 18 && !r)              slave_sda = ack2;
            else if (slot >= 10 && slot <= 17 && r) slave_sda = rb[17 - slot];
        end
    endtask

    int         fd;
    int         nd;
    logic       er;
    logic [7:0] rd;
    logic [3:0] snap;

    initial begin
        n_cmp     = 0;
        n_bad     = 0;
        rst_n     = 1'b0;
        start     = 1'b0;
        dev_addr  = 7'h00;
        rw        = 1'b0;
        wdata     = 8'h00;
        slave_sda = 1'b1;
        mon_clr   = 1'b1;
`ifdef I2C_CLOCK_STRETCH_EN
        scl_in    = 1'b1;
`endif
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_scl_oe",  {31'd0, scl_oe},  32'd0);
        check("rst_sda_oe",  {31'd0, sda_oe},  32'd0);
        check("rst_busy",    {31'd0, busy},    32'd0);
        check("rst_done",    {31'd0, done},    32'd0);
        check("rst_ack_err", {31'd0, ack_err}, 32'd0);
        check("rst_rdata",   {24'd0, rdata},   32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Write 0x42 / 0xA5, both bytes ACKed.
        run_txn(7'h42, 1'b0, 8'hA5, 1'b0, 1'b0, 8'h00, -1, -1, 0, 330, fd, nd, er, rd, snap);
        check("wr_done_t",  fd, 32'd320);
        check("wr_n_done",  nd, 32'd1);
        check("wr_ack_err", {31'd0, er}, 32'd0);
        check("wr_nbits",   mon_cnt, 32'd19);
        check("wr_bits",    mon_bits, {13'd0, 8'h84, 1'b1, 8'hA5, 1'b1, 1'b0});

        // Address NACK: no data slots, straight to STOP.
        run_txn(7'h42, 1'b0, 8'hA5, 1'b1, 1'b0, 8'h00, -1, -1, 0, 190, fd, nd, er, rd, snap);
        check("nack_done_t",  fd, 32'd176);
        check("nack_ack_err", {31'd0, er}, 32'd1);
        check("nack_nbits",   mon_cnt, 32'd10);
        check("nack_bits",    mon_bits, {22'd0, 8'h84, 1'b1, 1'b0});

        // Read 0x42, slave returns 0x3C; master NACKs the byte.
        run_txn(7'h42, 1'b1, 8'h00, 1'b0, 1'b0, 8'h3C, -1, -1, 0, 330, fd, nd, er, rd, snap);
        check("rd_done_t",  fd, 32'd320);
        check("rd_rdata",   {24'd0, rd}, {24'd0, 8'h3C});
        check("rd_ack_err", {31'd0, er}, 32'd0);
        check("rd_bits",    mon_bits, {13'd0, 8'h85, 1'b1, 8'hFF, 1'b1, 1'b0});
        check("rd_nbits",   mon_cnt, 32'd19);

        // Start pulsed while busy in DATA is ignored; then a full write follows.
        run_txn(7'h42, 1'b0, 8'hA5, 1'b0, 1'b0, 8'h00, 180, -1, 0, 340, fd, nd, er, rd, snap);
        check("busy_n_done", nd, 32'd1);
        check("busy_done_t", fd, 32'd320);
        run_txn(7'h55, 1'b0, 8'h0F, 1'b0, 1'b0, 8'h00, -1, -1, 0, 330, fd, nd, er, rd, snap);
        check("after_done_t",  fd, 32'd320);
        check("after_ack_err", {31'd0, er}, 32'd0);
        check("after_bits",    mon_bits, {13'd0, 8'hAA, 1'b1, 8'h0F, 1'b1, 1'b0});

        // Reset during DATA bit 3: lines released, no done, then a normal run.
        run_txn(7'h42, 1'b0, 8'hA5, 1'b0, 1'b0, 8'h00, -1, 210, 0, 340, fd, nd, er, rd, snap);
        check("rst_mid_snap",   {28'd0, snap}, 32'd0);
        check("rst_mid_n_done", nd, 32'd0);
        run_txn(7'h42, 1'b0, 8'hA5, 1'b0, 1'b0, 8'h00, -1, -1, 0, 330, fd, nd, er, rd, snap);
        check("post_rst_done_t", fd, 32'd320);
        check("post_rst_bits",   mon_bits, {13'd0, 8'h84, 1'b1, 8'hA5, 1'b1, 1'b0});

        // Start held in the DONE cycle is ignored, accepted one cycle later.
        run_txn(7'h42, 1'b0, 8'hA5, 1'b0, 1'b0, 8'h00, -1, -1, 0, 320, fd, nd, er, rd, snap);
        check("done_cyc_done_t", fd, 32'd320);
        dev_addr  = 7'h10;
        rw        = 1'b0;
        start     = 1'b1;
        slave_sda = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("start_in_done_ignored", {31'd0, busy}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        check("start_after_done_busy", {31'd0, busy}, 32'd1);
        fd = -1;
        er = 1'bx;
        for (int t = 1; t <= 400; t++) begin
            @(posedge clk);
            @(negedge clk);
            if (done && fd < 0) begin
                fd = t;
                er = ack_err;
            end
        end
        check("late_start_done_t",  fd, 32'd176);
        check("late_start_ack_err", {31'd0, er}, 32'd1);

`ifdef I2C_CLOCK_STRETCH_EN
        // Slave stretches ADDR bit 0 high phase by 10 cycles.
        run_txn(7'h42, 1'b0, 8'hA5, 1'b0, 1'b0, 8'h00, -1, -1, 1, 345, fd, nd, er, rd, snap);
        check("stretch_done_t", fd, 32'd330);
        check("stretch_bits",   mon_bits, {13'd0, 8'h84, 1'b1, 8'hA5, 1'b1, 1'b0});
        check("stretch_ack",    {31'd0, er}, 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/i2c_master_writer.md
Name: i2c_master_writer

Overview:
- Single-byte I2C bus master running on the system clock; the upstream stage that generates the SCL/SDA traffic our I2C slave receiver consumes.
- On a start request it issues START, the 7-bit address plus R/W bit, and one data byte (written or read), then STOP; it checks the slave ACKs.
- Open-drain style: drives the lines low via output enables and releases them otherwise.

Parameters:
- CLK_DIV, 4, system clock cycles per SCL quarter-period (legal range 2..255); one SCL bit period = 4*CLK_DIV cycles.

Ports:
- clk  in  1  system clock, all logic on posedge
- rst_n  in  1  synchronous active-low reset
- start  in  1  transaction request, sampled only when busy=0
- dev_addr  in  7  target address, captured on accepted start
- rw  in  1  0=write, 1=read; captured on accepted start
- wdata  in  8  write byte; captured on accepted start
- sda_in  in  1  sampled bus SDA level
- scl_oe  out  1  1=pull SCL low, 0=release
- sda_oe  out  1  1=pull SDA low, 0=release
- busy  out  1  transaction in progress
- done  out  1  one-cycle pulse at end of transaction
- ack_err  out  1  slave NACKed last transaction; held until next accepted start
- rdata  out  8  byte received in read transaction; held until next read

Behaviour:
- Reset (rst_n=0 at a clk edge): state IDLE, scl_oe=0, sda_oe=0, busy=0, done=0, ack_err=0, rdata=8'h00, quarter/bit counters cleared. Reset mid-transaction releases both lines on the next edge; no STOP is generated.
- Quarter timer: counts 0..CLK_DIV-1; a quarter ends when it hits CLK_DIV-1. Bit counter 0..7, MSB first.
- Bit slot (4 quarters): Q0 SCL low, SDA updated; Q1 SCL low; Q2 SCL released; Q3 SCL released. sda_in sampled on the last cycle of Q2.
- States:
  - IDLE: lines released. start=1 -> capture inputs, clear ack_err, go START, busy=1 from next cycle.
  - START (4 quarters): Q0-Q1 both released; Q2-Q3 SDA low, SCL released.
  - ADDR (8 slots): shifts {dev_addr, rw} = byte MSB first; bit=1 releases SDA, bit=0 pulls low.
  - ACK1 (1 slot): SDA released. Sample=1 -> ack_err=1, go STOP. Sample=0 -> go DATA.
  - DATA (8 slots): write shifts wdata MSB first. Read releases SDA and shifts sampled bits into a shadow register; rdata updated at end of slot 8.
  - ACK2 (1 slot): write releases SDA, sample=1 sets ack_err. Read releases SDA (NACK); no check.
  - STOP (4 quarters): Q0 SCL low, SDA low; Q1-Q2 SCL released, SDA low; Q3 both released.
  - DONE: 1 cycle; done=1, busy=0, return IDLE.
- Latency: start accepted at edge N -> done high at cycle N+1+80*CLK_DIV (full), N+1+44*CLK_DIV (address NACK).
- start while busy=1 is ignored and not queued. start=1 in the DONE cycle is ignored; start in the following IDLE cycle is accepted.
- SCL and SDA never change within the same quarter, except where START/STOP specify an SDA change while SCL is held released.

Optional Feature:
- I2C_CLOCK_STRETCH_EN defined: adds input port scl_in (1 bit). During Q2 of any bit slot and the STOP high quarters, the quarter timer holds at 0 while scl_in=0 (slave stretching). It resumes on the first cycle scl_in=1. Latency grows by the stretch cycles.
- Undefined: no scl_in port; the timer free-runs; fixed latency as above.

Test Plan:
- CLK_DIV=4, write dev_addr=7'h42, wdata=8'hA5, slave ACKs both -> SDA bits 1000_0100 then 1010_0101 on rising SCL; done at N+321; ack_err=0.
- Same with sda_in held 1 in ACK1 -> no data slots, STOP follows; done at N+177; ack_err=1.
- Read dev_addr=7'h42, slave drives 8'h3C -> address byte 8'h85, NACK slot SDA released, rdata=8'h3C at done; ack_err=0.
- Pulse start while busy during DATA -> ignored; exactly one done; next start after done runs a full transaction.
- Assert rst_n=0 during DATA bit 3 -> next edge scl_oe=0, sda_oe=0, busy=0, no done pulse; a new start works normally.
- With I2C_CLOCK_STRETCH_EN, hold scl_in=0 for 10 cycles in ADDR bit 0 Q2 -> done delayed by exactly 10 cycles (N+331); bit values unchanged.
